// File: rtl/tick_mmss_counter_display_pkg.sv
// ---------------------------------------------------------------------------
// tick_mmss_counter_display_pkg
// Shared constants for the mm:ss counter/display slice.
//   LO_MAX / HI_MAX : largest legal value of a units / tens digit
//   SEG_0..SEG_9    : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK       : all segments off
//   AN_OFF          : all digit enables off (active-low)
//   digit_max()     : limit for a digit position (0 = s_lo .. 3 = m_hi)
// ---------------------------------------------------------------------------
package tick_mmss_counter_display_pkg;

  localparam logic [3:0] LO_MAX = 4'd9;
  localparam logic [3:0] HI_MAX = 4'd5;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Odd positions (s_hi, m_hi) are tens digits and stop at 5.
  function automatic logic [3:0] digit_max(input logic [1:0] pos);
    return pos[0] ? HI_MAX : LO_MAX;
  endfunction

endpackage

// File: rtl/tick_mmss_counter_display_if.sv
// ---------------------------------------------------------------------------
// tick_mmss_counter_display_if
// Control inputs and display outputs of the mm:ss counter.
//   master : drives tick_in/run/up_dn/load/preset, observes bcd/wrap/an/seg
//   slave  : the counter itself
// ---------------------------------------------------------------------------
interface tick_mmss_counter_display_if;
  import tick_mmss_counter_display_pkg::*;

  logic        tick_in;
  logic        run;
  logic        up_dn;
  logic        load;
  logic [15:0] preset;
  logic [15:0] bcd;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output tick_in, run, up_dn, load, preset,
    input  bcd, wrap, an, seg
  );

  modport slave (
    input  tick_in, run, up_dn, load, preset,
    output bcd, wrap, an, seg
  );

endinterface

// File: rtl/tick_mmss_counter_display_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
//   bcd_i : 4-bit digit; codes 10..15 give a blank display
//   seg_o : segment drive, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_decode
  import tick_mmss_counter_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_mmss_counter_display.sv
// ---------------------------------------------------------------------------
// tick_mmss_counter_display
// BCD mm:ss counter (00:00..59:59) advanced by rising edges of a divided,
// I_CLK-synchronous square wave, driving a 4-digit multiplexed display.
//   I_CLK : system clock
//   rst   : synchronous active-high reset
//   bus   : slave side of tick_mmss_counter_display_if
//           (tick_in, run, up_dn, load, preset -> bcd, wrap, an, seg)
// Parameters:
//   SCAN_DIV : I_CLK cycles each digit stays lit (2..65535)
//   SCAN_W   : width of the scan prescaler
// ---------------------------------------------------------------------------
module tick_mmss_counter_display
  import tick_mmss_counter_display_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int SCAN_W   = 16
) (
  input  logic                         I_CLK,
  input  logic                         rst,
  tick_mmss_counter_display_if.slave   bus
);

  logic              tick_q;
  logic [15:0]       bcd_q;
  logic              wrap_q;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        scan_idx_q, scan_idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic        event_w;
  logic [15:0] preset_san;
  logic [15:0] count_d;
  logic        wrap_d;
  logic        carry;
  logic [3:0]  dig;
  logic [3:0]  lim;
  logic [3:0]  scan_digit;

  // tick_in shares I_CLK, so a plain one-cycle delay is enough for edges.
  assign event_w = bus.tick_in & ~tick_q;

  // Clamp each preset digit to its legal range.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_san
      localparam logic [3:0] LIM = (gi % 2 == 1) ? HI_MAX : LO_MAX;
      assign preset_san[gi*4 +: 4] =
        (preset_san_raw(gi) > LIM) ? LIM : preset_san_raw(gi);
    end
  endgenerate

  function automatic logic [3:0] preset_san_raw(input int pos);
    return bus.preset[pos*4 +: 4];
  endfunction

  // Ripple the +1/-1 through the digits; a carry out of m_hi is the wrap.
  always_comb begin
    count_d = bcd_q;
    carry   = 1'b1;
    dig     = 4'd0;
    lim     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      dig = bcd_q[i*4 +: 4];
      lim = digit_max(2'(i));
      if (carry) begin
        if (bus.up_dn) begin
          if (dig >= lim) begin
            count_d[i*4 +: 4] = 4'd0;
          end else begin
            count_d[i*4 +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            count_d[i*4 +: 4] = lim;
          end else begin
            count_d[i*4 +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap_d = carry;
  end

  always_comb begin
    case (scan_idx_q)
      2'd0:    scan_digit = bcd_q[3:0];
      2'd1:    scan_digit = bcd_q[7:4];
      2'd2:    scan_digit = bcd_q[11:8];
      default: scan_digit = bcd_q[15:12];
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd_i (scan_digit),
    .seg_o (seg_d)
  );

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
    an_d = ~(4'b0001 << scan_idx_q);
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      // tick_q starts high so a tick_in already high is not an edge.
      tick_q     <= 1'b1;
      bcd_q      <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      tick_q     <= bus.tick_in;
      wrap_q     <= 1'b0;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      if (bus.load) begin
        bcd_q <= preset_san;
      end else if (event_w && bus.run) begin
        bcd_q  <= count_d;
        wrap_q <= wrap_d;
      end
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.wrap = wrap_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;

endmodule

// File: tb/tb_tick_mmss_counter_display.sv
module tb_tick_mmss_counter_display;

  localparam int SD = 4;

  logic I_CLK;
  logic rst;

  tick_mmss_counter_display_if bus ();

  tick_mmss_counter_display #(.SCAN_DIV(SD), .SCAN_W(16)) dut (
    .I_CLK (I_CLK),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: value held as seconds within the hour.
  int       val;
  bit       m_wrap;
  bit       prev_tick;
  int       k;
  logic [3:0]  an_e;
  logic [6:0]  seg_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int clampi(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  function automatic int preset_val(input logic [15:0] p);
    int mh, ml, sh, sl;
    mh = clampi(int'(p[15:12]), 5);
    ml = clampi(int'(p[11:8]), 9);
    sh = clampi(int'(p[7:4]), 5);
    sl = clampi(int'(p[3:0]), 9);
    return (mh * 10 + ml) * 60 + sh * 10 + sl;
  endfunction

  task automatic model_step();
    bit ev;
    int idx;
    if (rst) begin
      val = 0; m_wrap = 0; prev_tick = 1; k = 0;
      an_e = 4'b1111; seg_e = 7'b1111111;
    end else begin
      idx   = (k / SD) % 4;
      an_e  = ~(4'b0001 << idx);
      seg_e = seg_of((val / (idx < 2 ? 1 : 60) % 60) / ((idx % 2 == 1) ? 10 : 1) % 10);
      k++;
      ev = bus.tick_in && !prev_tick;
      prev_tick = bus.tick_in;
      m_wrap = 0;
      if (bus.load) begin
        val = preset_val(bus.preset);
      end else if (ev && bus.run) begin
        if (bus.up_dn) begin
          m_wrap = (val == 3599);
          val = (val + 1) % 3600;
        end else begin
          m_wrap = (val == 0);
          val = (val + 3599) % 3600;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge I_CLK);
    model_step();
    #1;
    chk("bcd", 32'(bus.bcd), 32'(to_bcd(val)));
    chk("wrap", 32'(bus.wrap), 32'(m_wrap));
    chk("an", 32'(bus.an), 32'(an_e));
    chk("seg", 32'(bus.seg), 32'(seg_e));
  endtask

  task automatic tick_edge();
    bus.tick_in = 1'b0;
    cycle();
    bus.tick_in = 1'b1;
    cycle();
  endtask

  task automatic do_load(input logic [15:0] p);
    bus.load = 1'b1;
    bus.preset = p;
    cycle();
    bus.load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_in = 1'b1;
    bus.run = 1'b0;
    bus.up_dn = 1'b1;
    bus.load = 1'b0;
    bus.preset = 16'h0000;

    // Reset held with tick_in high, then released: no count, digit 0 lit.
    repeat (3) cycle();
    chk("rst_an", 32'(bus.an), 32'h0000_000F);
    rst = 1'b0;
    bus.run = 1'b1;
    cycle();
    chk("rel_an", 32'(bus.an), 32'h0000_000E);
    chk("rel_bcd", 32'(bus.bcd), 32'h0);
    cycle();
    chk("rel_nocount", 32'(bus.bcd), 32'h0);

    // Count up across the 59:59 wrap.
    do_load(16'h5958);
    bus.up_dn = 1'b1;
    tick_edge();
    chk("up_5959", 32'(bus.bcd), 32'h5959);
    tick_edge();
    chk("up_wrap_bcd", 32'(bus.bcd), 32'h0000);
    chk("up_wrap_pulse", 32'(bus.wrap), 32'h1);
    cycle();
    chk("up_wrap_gone", 32'(bus.wrap), 32'h0);

    // Count down across borrow and wrap.
    do_load(16'h1000);
    bus.up_dn = 1'b0;
    tick_edge();
    chk("dn_0959", 32'(bus.bcd), 32'h0959);
    chk("dn_nowrap", 32'(bus.wrap), 32'h0);
    do_load(16'h0000);
    tick_edge();
    chk("dn_wrap_bcd", 32'(bus.bcd), 32'h5959);
    chk("dn_wrap_pulse", 32'(bus.wrap), 32'h1);

    // Load wins over a coincident edge; preset sanitizing.
    bus.up_dn = 1'b1;
    bus.tick_in = 1'b0;
    cycle();
    bus.tick_in = 1'b1;
    do_load(16'h3007);
    chk("load_vs_edge", 32'(bus.bcd), 32'h3007);
    cycle();
    chk("edge_dropped", 32'(bus.bcd), 32'h3007);
    do_load(16'h7A6F);
    chk("sanitize", 32'(bus.bcd), 32'h5959);

    // run=0 ignores edges.
    bus.run = 1'b0;
    repeat (5) tick_edge();
    chk("run0_hold", 32'(bus.bcd), 32'h5959);

    // Fastest tick (toggle every cycle): 20 cycles give 10 counts.
    bus.run = 1'b1;
    bus.tick_in = 1'b0;
    do_load(16'h0000);
    for (int i = 0; i < 20; i++) begin
      bus.tick_in = ~bus.tick_in;
      cycle();
    end
    chk("fast_ticks", 32'(bus.bcd), 32'h0010);

    // Display scan of 12:34.
    bus.run = 1'b0;
    do_load(16'h1234);
    repeat (3 * 4 * SD) cycle();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) bus.tick_in = ~bus.tick_in;
      bus.run = ($urandom_range(0, 9) < 8);
      bus.up_dn = $urandom_range(0, 1) == 1;
      bus.load = ($urandom_range(0, 39) == 0);
      bus.preset = 16'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
